// File: rtl/mod_counter_ext.sv
// mod_counter_ext: parametrised modulo-N counter with prescaler, up/down
// direction, parallel load, synchronous clear and wrap/saturate boundary mode.
// The tc output is a registered one-cycle pulse suitable for cascading into
// the en input of a further instance.
module mod_counter_ext #(
   parameter int WIDTH    = 6,
   parameter int MODULUS  = 41,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             mode,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             sat
);

   // Prescaler width: at least one bit so PRESCALE=1 still has a legal vector.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO    = '0;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [PW-1:0]    PSC_MAX = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PSC_ONE = PW'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    psc_q, psc_d;
   logic             tc_q, tc_d;
   logic             sat_q, sat_d;
   logic             step;
   logic [WIDTH-1:0] bnd;
   logic [WIDTH-1:0] nxt;

   // Out-of-range load values clamp to the top of the count range. Comparing
   // against MAX_CNT keeps everything within WIDTH bits even when
   // MODULUS == 2**WIDTH.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX_CNT) ? MAX_CNT : v;
   endfunction

   // Next-state logic: load > clr > prescaled step > hold.
   always_comb begin
      cnt_d = cnt_q;
      psc_d = psc_q;
      tc_d  = 1'b0;
      step  = 1'b0;
      nxt   = cnt_q;
      bnd   = up ? MAX_CNT : ZERO;

      if (load) begin
         cnt_d = clamp_load(din);
         psc_d = '0;
      end else if (clr) begin
         cnt_d = ZERO;
         psc_d = '0;
      end else if (en) begin
         if (psc_q == PSC_MAX) begin
            psc_d = '0;
            step  = 1'b1;
         end else begin
            psc_d = psc_q + PSC_ONE;
         end
      end

      if (step) begin
         if (cnt_q == bnd) begin
            // At the boundary: wrap (with tc) or hold in saturate mode.
            if (!mode) begin
               cnt_d = up ? ZERO : MAX_CNT;
               tc_d  = 1'b1;
            end
         end else begin
            // Boundary compare above guarantees no over/underflow here.
            nxt   = up ? (cnt_q + ONE) : (cnt_q - ONE);
            cnt_d = nxt;
            tc_d  = mode && (nxt == bnd);
         end
      end

      // Saturation flag tracks the next count against the current direction.
      sat_d = mode && (cnt_d == bnd);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         psc_q <= '0;
         tc_q  <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         psc_q <= psc_d;
         tc_q  <= tc_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = tc_q;
   assign sat = sat_q;

endmodule

// File: tb/tb_mod_counter_ext.sv
// tb_mod_counter_ext: drives a PRESCALE=1 and a PRESCALE=4 instance of the
// mod-41 counter with shared inputs and checks both against a behavioural
// model every cycle, plus directed sequences with literal expectations.
module tb_mod_counter_ext;

   localparam int M = 41;

   logic       clk, rst, en, up, mode, clr, load;
   logic [5:0] din;
   logic [5:0] cnt1, cnt4;
   logic       tc1, sat1, tc4, sat4;

   int checks   = 0;
   int failures = 0;

   int m_cnt[2];
   int m_psc[2];
   int m_tc[2];
   int m_sat[2];

   mod_counter_ext #(.WIDTH(6), .MODULUS(M), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clr(clr),
      .load(load), .din(din), .cnt(cnt1), .tc(tc1), .sat(sat1)
   );

   mod_counter_ext #(.WIDTH(6), .MODULUS(M), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clr(clr),
      .load(load), .din(din), .cnt(cnt4), .tc(tc4), .sat(sat4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int ps(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_sat[i] = 0;
      end
   endtask

   // One clock edge of the counter rules, applied to model instance i.
   task automatic model_edge(input int i);
      int b;
      bit do_step;
      b = up ? (M - 1) : 0;
      do_step = 0;
      m_tc[i] = 0;
      if (load) begin
         m_cnt[i] = (int'(din) >= M) ? (M - 1) : int'(din);
         m_psc[i] = 0;
      end else if (clr) begin
         m_cnt[i] = 0;
         m_psc[i] = 0;
      end else if (en) begin
         m_psc[i] = m_psc[i] + 1;
         if (m_psc[i] == ps(i)) begin
            m_psc[i] = 0;
            do_step = 1;
         end
      end
      if (do_step) begin
         if (m_cnt[i] == b) begin
            if (!mode) begin
               m_cnt[i] = up ? 0 : (M - 1);
               m_tc[i] = 1;
            end
         end else begin
            m_cnt[i] = up ? (m_cnt[i] + 1) : (m_cnt[i] - 1);
            m_tc[i] = (mode && m_cnt[i] == b) ? 1 : 0;
         end
      end
      m_sat[i] = (mode && m_cnt[i] == b) ? 1 : 0;
   endtask

   task automatic compare_all();
      chk("cnt1", int'(cnt1), m_cnt[0]);
      chk("tc1",  int'(tc1),  m_tc[0]);
      chk("sat1", int'(sat1), m_sat[0]);
      chk("cnt4", int'(cnt4), m_cnt[1]);
      chk("tc4",  int'(tc4),  m_tc[1]);
      chk("sat4", int'(sat4), m_sat[1]);
   endtask

   // Advance one edge: model follows the inputs seen at the edge, outputs
   // are sampled 1 ns later.
   task automatic cyc();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      compare_all();
   endtask

   task automatic set_in(input bit e, input bit u, input bit md, input bit c,
                         input bit l, input int d);
      en = e; up = u; mode = md; clr = c; load = l; din = 6'(d);
   endtask

   int exp_seq[$];
   int exp_tc[$];

   initial begin
      rst = 1'b1;
      set_in(0, 1, 0, 0, 0, 0);
      #1 rst = 1'b0;
      model_reset();
      #48;
      chk("reset_cnt", int'(cnt1), 0);
      chk("reset_tc",  int'(tc1),  0);
      chk("reset_sat", int'(sat1), 0);
      chk("reset_cnt4", int'(cnt4), 0);
      #1 rst = 1'b1;  // released at 50 ns, between edges

      // Wrap upward: 0..40 then 0, tc with the 0 after 40.
      set_in(1, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 42; k++) begin
         cyc();
         chk("wrap_cnt", int'(cnt1), k % M);
         chk("wrap_tc",  int'(tc1),  (k == 41) ? 1 : 0);
      end

      // Down wrap from 2: 2,1,0,40,39 with tc at 40.
      set_in(0, 0, 0, 0, 1, 2);
      cyc();
      chk("dn_load", int'(cnt1), 2);
      set_in(1, 0, 0, 0, 0, 0);
      exp_seq = '{1, 0, 40, 39};
      exp_tc  = '{0, 0, 1, 0};
      foreach (exp_seq[j]) begin
         cyc();
         chk("dn_cnt", int'(cnt1), exp_seq[j]);
         chk("dn_tc",  int'(tc1),  exp_tc[j]);
      end

      // Saturate upward from 38.
      set_in(0, 1, 1, 0, 1, 38);
      cyc();
      chk("sat_load", int'(cnt1), 38);
      set_in(1, 1, 1, 0, 0, 0);
      exp_seq = '{39, 40, 40, 40};
      exp_tc  = '{0, 1, 0, 0};
      foreach (exp_seq[j]) begin
         cyc();
         chk("sat_cnt", int'(cnt1), exp_seq[j]);
         chk("sat_tc",  int'(tc1),  exp_tc[j]);
         chk("sat_sat", int'(sat1), (exp_seq[j] == 40) ? 1 : 0);
      end
      up = 1'b0;
      cyc();
      chk("sat_rev_cnt", int'(cnt1), 39);
      chk("sat_rev_sat", int'(sat1), 0);
      cyc();
      chk("sat_rev_cnt2", int'(cnt1), 38);

      // Load beats clear, out-of-range value clamps.
      set_in(0, 1, 0, 1, 1, 55);
      cyc();
      chk("clamp_cnt", int'(cnt1), 40);
      chk("clamp_tc",  int'(tc1),  0);
      load = 1'b0;
      cyc();
      chk("clr_cnt", int'(cnt1), 0);

      // Prescaler phase survives an en gap of 3 cycles.
      set_in(1, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk("psc_cnt", int'(cnt4), (k >= 4) ? 1 : 0);
      end
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("psc_hold", int'(cnt4), 1);
      end
      en = 1'b1;
      cyc();
      chk("psc_pre", int'(cnt4), 1);
      cyc();
      chk("psc_step", int'(cnt4), 2);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         en   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) up = ~up;
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         clr  = ($urandom_range(0, 79) == 0);
         load = ($urandom_range(0, 59) == 0);
         din  = 6'($urandom_range(0, 63));
         cyc();
      end

      // Async reset mid-count at 17.
      set_in(0, 1, 0, 1, 0, 0);
      cyc();
      set_in(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 17; k++) cyc();
      chk("pre_arst_cnt", int'(cnt1), 17);
      #3 rst = 1'b0;
      #1;
      model_reset();
      chk("arst_cnt", int'(cnt1), 0);
      chk("arst_tc",  int'(tc1),  0);
      chk("arst_cnt4", int'(cnt4), 0);
      #2 rst = 1'b1;
      for (int k = 0; k < 50; k++) begin
         en = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
